// File: rtl/rgmii_pkg.sv
// Shared RGMII receive definitions: framer states and preamble/SFD byte values.
package rgmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDrop
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/rgmii_rx_framer_if.sv
// Streaming payload output of the RGMII receive framer (no backpressure).
interface rgmii_rx_framer_if #(
  parameter int unsigned OUT_BYTES = 4
);
  logic [8*OUT_BYTES-1:0] m_tdata;
  logic [OUT_BYTES-1:0]   m_tkeep;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   m_tuser;

  modport master (output m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser);
  modport slave  (input  m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser);
endinterface

// File: rtl/rgmii_rx_nibble_pack.sv
// Turns the RGMII receive stream into bytes: pass-through at 1000, low-nibble-first pairs at 10/100.
module rgmii_rx_nibble_pack (
  input  logic       clk,
  input  logic       rst,
  input  logic       speed,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       half
);

  logic       half_q, half_d;
  logic [3:0] low_q, low_d;

  always_comb begin
    half_d     = half_q;
    low_d      = low_q;
    byte_data  = rx_data;
    byte_valid = 1'b0;
    if (!rx_dv) begin
      half_d = 1'b0;
    end else if (speed) begin
      byte_valid = 1'b1;
      half_d     = 1'b0;
    end else if (half_q) begin
      byte_data  = {rx_data[3:0], low_q};
      byte_valid = 1'b1;
      half_d     = 1'b0;
    end else begin
      low_d  = rx_data[3:0];
      half_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      half_q <= 1'b0;
      low_q  <= 4'd0;
    end else begin
      half_q <= half_d;
      low_q  <= low_d;
    end
  end

  // A held nibble when rx_dv drops marks an odd-length frame.
  assign half = half_q;

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, packs payload into OUT_BYTES-wide beats and
// keeps saturating good/bad frame counters.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int unsigned OUT_BYTES = 4,
  parameter int unsigned MAX_PRE   = 7,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_125,
  input  logic              rst,
  input  logic              speed_1g,
  input  logic [7:0]        rx_data,
  input  logic              rx_dv,
  input  logic              rx_er,
  rgmii_rx_framer_if.master m,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned DataW    = 8 * OUT_BYTES;
  localparam logic [3:0]  LastLane = 4'(OUT_BYTES - 1);

  rx_state_e            state_q, state_d, pre_next;
  logic                 speed_q, speed_d, eff_speed;
  logic                 armed_q, armed_d;
  logic [7:0]           pre_cnt_q, pre_cnt_d, pre_seen, pre_cnt_n;
  logic [DataW-1:0]     acc_q, acc_d, acc_new, pend_q, pend_d;
  logic [3:0]           acc_cnt_q, acc_cnt_d;
  logic                 pend_vld_q, pend_vld_d, err_q, err_d;
  logic [DataW-1:0]     tdata_q, tdata_d;
  logic [OUT_BYTES-1:0] tkeep_q, tkeep_d, partial_keep;
  logic                 tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic                 drop_exit;
  logic [7:0]           byte_data;
  logic                 byte_valid, half;

  // Speed is taken live while idle so the first nibble/byte of a frame is decoded correctly.
  assign eff_speed = (state_q == StIdle) ? speed_1g : speed_q;

  rgmii_rx_nibble_pack u_pack (
    .clk        (clk_125),
    .rst        (rst),
    .speed      (eff_speed),
    .rx_data    (rx_data),
    .rx_dv      (rx_dv),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .half       (half)
  );

  // Preamble step shared by the frame-start cycle and the PREAMBLE state.
  always_comb begin
    pre_seen  = (state_q == StIdle) ? 8'd0 : pre_cnt_q;
    pre_next  = StPreamble;
    pre_cnt_n = pre_seen;
    if (rx_er) begin
      pre_next = StDrop;
    end else if (byte_valid) begin
      if (byte_data == SFD_BYTE) begin
        pre_next = StData;
      end else if (byte_data == PREAMBLE_BYTE && pre_seen != 8'(MAX_PRE)) begin
        pre_cnt_n = pre_seen + 8'd1;
      end else begin
        pre_next = StDrop;
      end
    end
  end

  always_comb begin
    acc_new = acc_q;
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      if (acc_cnt_q == 4'(i)) acc_new[8*i +: 8] = byte_data;
      partial_keep[i] = (4'(i) < acc_cnt_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    armed_d     = armed_q | ~rx_dv;
    pre_cnt_d   = pre_cnt_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    err_d       = err_q;
    tdata_d     = '0;
    tkeep_d     = '0;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    drop_exit   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        speed_d    = speed_1g;
        acc_d      = '0;
        acc_cnt_d  = 4'd0;
        pend_d     = '0;
        pend_vld_d = 1'b0;
        err_d      = 1'b0;
        pre_cnt_d  = 8'd0;
        if (rx_dv && armed_q) begin
          state_d   = pre_next;
          pre_cnt_d = pre_cnt_n;
        end
      end
      StPreamble: begin
        if (!rx_dv) begin
          state_d   = StIdle;
          drop_exit = 1'b1;
        end else begin
          state_d   = pre_next;
          pre_cnt_d = pre_cnt_n;
        end
      end
      StData: begin
        if (!rx_dv) begin
          state_d = StIdle;
          if (acc_cnt_q != 4'd0) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = acc_q;
            tkeep_d  = partial_keep;
            tuser_d  = err_q | half;
          end else if (pend_vld_q) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = pend_q;
            tkeep_d  = '1;
            tuser_d  = err_q | half;
          end else begin
            drop_exit = 1'b1;
          end
        end else begin
          if (rx_er) err_d = 1'b1;
          if (byte_valid) begin
            if (pend_vld_q) begin
              tvalid_d   = 1'b1;
              tdata_d    = pend_q;
              tkeep_d    = '1;
              pend_vld_d = 1'b0;
            end
            if (acc_cnt_q == LastLane) begin
              pend_d     = acc_new;
              pend_vld_d = 1'b1;
              acc_d      = '0;
              acc_cnt_d  = 4'd0;
            end else begin
              acc_d     = acc_new;
              acc_cnt_d = acc_cnt_q + 4'd1;
            end
          end
        end
      end
      StDrop: begin
        if (!rx_dv) begin
          state_d   = StIdle;
          drop_exit = 1'b1;
        end
      end
    endcase

    if ((tlast_d && tuser_d) || drop_exit) begin
      if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
    end else if (tlast_d) begin
      if (frame_cnt_q != {CNT_W{1'b1}}) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_125) begin
    if (!rst) begin
      state_q     <= StIdle;
      speed_q     <= 1'b0;
      armed_q     <= 1'b0;
      pre_cnt_q   <= 8'd0;
      acc_q       <= '0;
      acc_cnt_q   <= 4'd0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      armed_q     <= armed_d;
      pre_cnt_q   <= pre_cnt_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      err_q       <= err_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign m.m_tdata  = tdata_q;
  assign m.m_tkeep  = tkeep_q;
  assign m.m_tvalid = tvalid_q;
  assign m.m_tlast  = tlast_q;
  assign m.m_tuser  = tuser_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed and randomized frames against a byte-list reference model of the framer.
module tb_rgmii_rx_framer;

  localparam int MaxPre = 7;

  logic        clk = 1'b0;
  logic        rst, speed_1g, rx_dv, rx_er;
  logic [7:0]  rx_data;
  logic [15:0] frame_cnt, err_cnt;

  rgmii_rx_framer_if #(.OUT_BYTES(4)) bus ();

  rgmii_rx_framer #(
    .OUT_BYTES (4),
    .MAX_PRE   (MaxPre),
    .CNT_W     (16)
  ) dut (
    .clk_125   (clk),
    .rst       (rst),
    .speed_1g  (speed_1g),
    .rx_data   (rx_data),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .m         (bus),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_errs = 0;
  int fall_edge = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] exp_data[$], obs_data[$];
  logic [3:0]  exp_keep[$], obs_keep[$];
  logic        exp_last[$], obs_last[$], exp_user[$], obs_user[$];
  int          obs_cyc[$];

  always @(negedge clk) begin
    if (bus.m_tvalid) begin
      obs_data.push_back(bus.m_tdata);
      obs_keep.push_back(bus.m_tkeep);
      obs_last.push_back(bus.m_tlast);
      obs_user.push_back(bus.m_tuser);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    rx_dv   = dv;
    rx_er   = er;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  // Expected beats derived from the byte list: strip 0x55 run + 0xD5, chunk payload by 4.
  task automatic model_frame(input int er_idx, input bit odd);
    int          i, n;
    bit          drop, bad, last;
    logic [7:0]  pay[$];
    logic [31:0] d;
    logic [3:0]  k;
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_user.delete();
    n = tx_q.size();
    i = 0;
    while (i < n && tx_q[i] == 8'h55) i++;
    drop = (i > MaxPre) || (i >= n);
    if (!drop) drop = (tx_q[i] != 8'hD5);
    if (er_idx >= 0 && er_idx <= i) drop = 1'b1;
    if (drop) begin
      exp_errs++;
      return;
    end
    for (int j = i + 1; j < n; j++) pay.push_back(tx_q[j]);
    bad = odd || (er_idx > i);
    if (pay.size() == 0) begin
      exp_errs++;
      return;
    end
    for (int b = 0; b < pay.size(); b += 4) begin
      d = '0;
      k = '0;
      for (int l = 0; l < 4; l++) begin
        if (b + l < pay.size()) begin
          d[8*l +: 8] = pay[b+l];
          k[l]        = 1'b1;
        end
      end
      last = (b + 4 >= pay.size());
      exp_data.push_back(d);
      exp_keep.push_back(k);
      exp_last.push_back(last);
      exp_user.push_back(last ? bad : 1'b0);
    end
    if (bad) exp_errs++;
    else exp_frames++;
  endtask

  // Speed input is flipped mid-frame; the framer must keep the speed latched at frame start.
  task automatic send_frame(input bit sp, input int er_idx, input bit odd);
    logic e;
    speed_1g = sp;
    for (int j = 0; j < tx_q.size(); j++) begin
      e = (j == er_idx);
      if (j == 2) speed_1g = ~sp;
      if (sp) begin
        drive(1'b1, e, tx_q[j]);
      end else begin
        drive(1'b1, e, {4'($urandom), tx_q[j][3:0]});
        drive(1'b1, e, {4'($urandom), tx_q[j][7:4]});
      end
    end
    if (odd && !sp) drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'($urandom));
    fall_edge = cyc;
    speed_1g  = sp;
    repeat (4) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_nbeats"}, 64'(obs_data.size()), 64'(exp_data.size()));
    for (int b = 0; b < exp_data.size() && b < obs_data.size(); b++) begin
      chk($sformatf("%s_b%0d_data", tag, b), 64'(obs_data[b]), 64'(exp_data[b]));
      chk($sformatf("%s_b%0d_keep", tag, b), 64'(obs_keep[b]), 64'(exp_keep[b]));
      chk($sformatf("%s_b%0d_last", tag, b), 64'(obs_last[b]), 64'(exp_last[b]));
      chk($sformatf("%s_b%0d_user", tag, b), 64'(obs_user[b]), 64'(exp_user[b]));
    end
    if (exp_data.size() > 0 && obs_data.size() > 0)
      chk({tag, "_eof_cycle"}, 64'(obs_cyc[obs_cyc.size()-1]), 64'(fall_edge));
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_errs));
  endtask

  task automatic run_frame(input string tag, input bit sp, input int er_idx, input bit odd);
    obs_data.delete(); obs_keep.delete(); obs_last.delete(); obs_user.delete();
    obs_cyc.delete();
    model_frame(er_idx, odd && !sp);
    send_frame(sp, er_idx, odd);
    compare_frame(tag);
  endtask

  task automatic build_frame(input int npre, input int plen, input bit rnd);
    tx_q.delete();
    for (int j = 0; j < npre; j++) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int j = 0; j < plen; j++) tx_q.push_back(rnd ? 8'($urandom) : 8'(j + 1));
  endtask

  initial begin
    int  npre, plen, kind, er_idx;
    bit  sp, odd;
    logic [7:0] bb;

    rst = 1'b0; speed_1g = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus.m_tlast), 64'd0);
    chk("rst_tuser", 64'(bus.m_tuser), 64'd0);
    chk("rst_tdata", 64'(bus.m_tdata), 64'd0);
    chk("rst_tkeep", 64'(bus.m_tkeep), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00);

    // 1G, 7x55 + D5 + 01..0A
    build_frame(7, 10, 1'b0);
    run_frame("g1_10b", 1'b1, -1, 1'b0);
    if (obs_data.size() == 3) begin
      chk("g1_const_b0", 64'(obs_data[0]), 64'h04030201);
      chk("g1_const_b1", 64'(obs_data[1]), 64'h08070605);
      chk("g1_const_b2", 64'(obs_data[2]), 64'h00000A09);
      chk("g1_const_keep2", 64'(obs_keep[2]), 64'b0011);
    end
    chk("g1_const_frames", 64'(frame_cnt), 64'd1);

    // Same frame as nibbles
    run_frame("nib_10b", 1'b0, -1, 1'b0);
    if (obs_data.size() == 3) chk("nib_const_b2", 64'(obs_data[2]), 64'h00000A09);

    // 8 payload bytes: last beat is the full pending word
    build_frame(7, 8, 1'b0);
    run_frame("g1_8b", 1'b1, -1, 1'b0);

    // rx_er on third payload byte
    build_frame(7, 10, 1'b1);
    run_frame("g1_er", 1'b1, 7 + 1 + 2, 1'b0);

    // Bad preamble byte, then a normal frame
    tx_q.delete();
    tx_q.push_back(8'h55); tx_q.push_back(8'h55); tx_q.push_back(8'hAA);
    tx_q.push_back(8'h55); tx_q.push_back(8'hD5); tx_q.push_back(8'h11);
    run_frame("bad_pre", 1'b1, -1, 1'b0);
    build_frame(7, 6, 1'b1);
    run_frame("after_bad_pre", 1'b1, -1, 1'b0);

    // Reset pulse mid-payload; remainder of that frame must be ignored
    obs_data.delete(); obs_keep.delete(); obs_last.delete(); obs_user.delete();
    obs_cyc.delete();
    build_frame(7, 6, 1'b1);
    speed_1g = 1'b1;
    for (int j = 0; j < 11; j++) drive(1'b1, 1'b0, tx_q[j]);
    rst = 1'b0;
    drive(1'b1, 1'b0, tx_q[11]);
    rst = 1'b1;
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    for (int j = 12; j < tx_q.size(); j++) drive(1'b1, 1'b0, tx_q[j]);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    exp_frames = 0;
    exp_errs   = 0;
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_user.delete();
    compare_frame("midrst");
    build_frame(7, 9, 1'b1);
    run_frame("after_rst", 1'b1, -1, 1'b0);

    // Randomized frames: speed, preamble length, payload length, errors, odd nibble
    for (int f = 0; f < 30; f++) begin
      sp   = 1'($urandom_range(0, 1));
      npre = $urandom_range(1, 7);
      kind = $urandom_range(0, 9);
      plen = $urandom_range(0, 20);
      if (kind == 0) npre = 8;
      tx_q.delete();
      for (int j = 0; j < npre; j++) tx_q.push_back(8'h55);
      if (kind == 1) begin
        bb = 8'($urandom);
        if (bb == 8'h55 || bb == 8'hD5) bb = 8'h00;
        tx_q.push_back(bb);
      end
      tx_q.push_back(8'hD5);
      for (int j = 0; j < plen; j++) tx_q.push_back(8'($urandom));
      er_idx = (kind == 2) ? $urandom_range(0, tx_q.size() - 1) : -1;
      odd    = (kind == 3);
      run_frame($sformatf("rnd%0d", f), sp, er_idx, odd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
